// File: rtl/led_scan_scheduler.sv
// led_scan_scheduler: row-scan/blanking sequencer for an 8x8 RGB matrix with a double-buffered frame store and 2-digit 7-seg mux
// Ports: CLK/reset (sync, active-high); wr_en/wr_row/wr_red/wr_green/wr_blue write a row of the back buffer;
// swap_req asks for a front/back swap at the next frame boundary, swap_ack pulses when it commits;
// blank_all forces the matrix dark; digit_ones/digit_tens are BCD score digits;
// led = {red[0:7], green[8:15], blue[16:23] active-low, row[24:26], enable[27]}; seg active-low {a..g};
// COM digit select (01 ones, 10 tens); frame_start pulses at the start of each row-0 period.
module led_scan_scheduler #(
    parameter int TICK_DIV     = 25000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [2:0]  wr_row,
    input  logic [7:0]  wr_red,
    input  logic [7:0]  wr_green,
    input  logic [7:0]  wr_blue,
    input  logic        swap_req,
    output logic        swap_ack,
    input  logic        blank_all,
    input  logic [3:0]  digit_ones,
    input  logic [3:0]  digit_tens,
    output logic [0:27] led,
    output logic [6:0]  seg,
    output logic [1:0]  COM,
    output logic        frame_start
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] BLK  = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    row_q, row_d;
    logic          front_q;
    logic          pend_q, pend_d;
    logic [3:0]    ones_q, tens_q;
    logic [23:0]   mem_q [2][8];
    logic          wrap, eof, commit, dark;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b0000001;
            4'd1:    decode = 7'b1001111;
            4'd2:    decode = 7'b0010010;
            4'd3:    decode = 7'b0000110;
            4'd4:    decode = 7'b1001100;
            4'd5:    decode = 7'b0100100;
            4'd6:    decode = 7'b0100000;
            4'd7:    decode = 7'b0001111;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0000100;
            default: decode = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        wrap   = cnt_q == LAST;
        eof    = wrap && row_q == 3'd7;
        // a request landing in the commit cycle rides along with that commit
        commit = eof && (pend_q || swap_req);
        dark   = cnt_q < BLK || blank_all;
        cnt_d  = wrap ? '0 : cnt_q + 1'b1;
        row_d  = wrap ? row_q + 3'd1 : row_q;
        pend_d = commit ? 1'b0 : pend_q | swap_req;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            cnt_q       <= '0;
            row_q       <= '0;
            front_q     <= 1'b0;
            pend_q      <= 1'b0;
            ones_q      <= '0;
            tens_q      <= '0;
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < 8; r++)
                    mem_q[b][r] <= '1;
            led         <= {24'hFFFFFF, 3'd0, 1'b0};
            seg         <= 7'b0000001;
            COM         <= 2'b01;
            swap_ack    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            front_q <= front_q ^ commit;
            pend_q  <= pend_d;
            if (eof) begin
                ones_q <= digit_ones;
                tens_q <= digit_tens;
            end
            // back buffer is chosen by the pre-toggle front, so a commit-cycle write lands in the new front
            if (wr_en)
                mem_q[~front_q][wr_row] <= {wr_red, wr_green, wr_blue};
            led         <= {dark ? 24'hFFFFFF : mem_q[front_q][row_q], row_q, ~dark};
            seg         <= decode(row_q[0] ? tens_q : ones_q);
            COM         <= row_q[0] ? 2'b10 : 2'b01;
            swap_ack    <= commit;
            frame_start <= eof;
        end
    end
endmodule

// File: tb/tb_led_scan_scheduler.sv
// tb_led_scan_scheduler: randomized scoreboard bench for led_scan_scheduler against a frame-level model
module tb_led_scan_scheduler;
    localparam int TD = 8;
    localparam int BL = 2;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_row = '0;
    logic [7:0]  wr_red = '0, wr_green = '0, wr_blue = '0;
    logic        swap_req = 1'b0, blank_all = 1'b0;
    logic [3:0]  digit_ones = '0, digit_tens = '0;
    logic        swap_ack, frame_start;
    logic [0:27] led;
    logic [6:0]  seg;
    logic [1:0]  COM;

    led_scan_scheduler #(.TICK_DIV(TD), .BLANK_CYCLES(BL)) dut (
        .CLK(CLK), .reset(reset), .wr_en(wr_en), .wr_row(wr_row),
        .wr_red(wr_red), .wr_green(wr_green), .wr_blue(wr_blue),
        .swap_req(swap_req), .swap_ack(swap_ack), .blank_all(blank_all),
        .digit_ones(digit_ones), .digit_tens(digit_tens),
        .led(led), .seg(seg), .COM(COM), .frame_start(frame_start)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [0:27] led;
        logic [6:0]  seg;
        logic [1:0]  com;
        logic        ack;
        logic        fs;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [6:0] dec_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b1111111, 7'b1111111,
                                 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};

    // model state: elapsed cycles since reset, displayed and hidden images, pending swap, frozen score
    int          t;
    logic [23:0] shown [8];
    logic [23:0] hidden [8];
    bit          pend;
    logic [3:0]  lat_ones, lat_tens;

    task automatic step();
        exp_t e;
        int c, r;
        bit eof, dark, ack;
        logic [23:0] tmp;
        if (reset) begin
            e.led = {24'hFFFFFF, 3'd0, 1'b0};
            e.seg = 7'b0000001;
            e.com = 2'b01;
            e.ack = 1'b0;
            e.fs  = 1'b0;
            q.push_back(e);
            t = 0;
            pend = 0;
            lat_ones = '0;
            lat_tens = '0;
            for (int i = 0; i < 8; i++) begin
                shown[i]  = 24'hFFFFFF;
                hidden[i] = 24'hFFFFFF;
            end
        end else begin
            c = t % TD;
            r = (t / TD) % 8;
            eof  = (c == TD - 1) && (r == 7);
            dark = (c < BL) || blank_all;
            ack  = eof && (pend || swap_req);
            e.led = {dark ? 24'hFFFFFF : shown[r], 3'(r), !dark};
            e.seg = dec_tab[(r % 2) ? lat_tens : lat_ones];
            e.com = (r % 2) ? 2'b10 : 2'b01;
            e.ack = ack;
            e.fs  = eof;
            q.push_back(e);
            if (wr_en) hidden[wr_row] = {wr_red, wr_green, wr_blue};
            if (ack)
                for (int i = 0; i < 8; i++) begin
                    tmp = shown[i];
                    shown[i] = hidden[i];
                    hidden[i] = tmp;
                end
            pend = ack ? 1'b0 : (pend || swap_req);
            if (eof) begin
                lat_ones = digit_ones;
                lat_tens = digit_tens;
            end
            t++;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d actual %h required %h", name, cyc, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            cyc++;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("led", 32'(led), 32'(e.led));
                chk("seg", 32'(seg), 32'(e.seg));
                chk("com", 32'(COM), 32'(e.com));
                chk("swap_ack", 32'(swap_ack), 32'(e.ack));
                chk("frame_start", 32'(frame_start), 32'(e.fs));
            end
        end
    end

    initial begin : driver
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            reset = 1'b1;
            step();
        end
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            reset     = ($urandom_range(0, 399) == 0);
            wr_en     = ($urandom_range(0, 2) == 0);
            wr_row    = 3'($urandom_range(0, 7));
            wr_red    = 8'($urandom);
            wr_green  = 8'($urandom);
            wr_blue   = 8'($urandom);
            // alternate busy-swap and quiet stretches so both multi-request and request-free frames occur
            swap_req  = ((i / 256) % 2 == 0) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 199) == 0);
            blank_all = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 19) == 0) digit_ones = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) digit_tens = 4'($urandom_range(0, 15));
            step();
        end
        @(negedge CLK);
        reset = 1'b0;
        wr_en = 1'b0;
        swap_req = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual %0d required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
